// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed address/data bus master.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_GAP,
        ST_DATA,
        ST_END
    } state_e;

    localparam logic A_D_ADDR = 1'b0;
    localparam logic A_D_DATA = 1'b1;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/tristate_io_reg.sv
// Tristate pad driver with a synchronously reset per-cycle input capture register.
module tristate_io_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         oe_i,
    input  logic [W-1:0] out_i,
    inout  wire  [W-1:0] pad_io,
    output logic [W-1:0] in_o,
    output logic [W-1:0] sample_o
);

    logic [W-1:0] sample_q;

    assign pad_io   = oe_i ? out_i : {W{1'bz}};
    assign in_o     = pad_io;
    assign sample_o = sample_q;

    always_ff @(posedge clock) begin
        if (reset) sample_q <= '0;
        else       sample_q <= pad_io;
    end

endmodule

// File: rtl/rtc_ad_bus_ctrl.sv
// Single-beat bus master for the RTC chip: address, turnaround, data and end
// phases of PHASE_CYCLES clocks each on a shared tristate AD bus.
module rtc_ad_bus_ctrl #(
    parameter int DATA_W       = 8,
    parameter int PHASE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    inout  wire  [DATA_W-1:0] ad_bus,
    output logic              cs_n,
    output logic              rd_n,
    output logic              wr_n,
    output logic              a_d,
    output logic [DATA_W-1:0] bus_sample
);
    import rtc_bus_pkg::*;

    localparam int CW = $clog2(PHASE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rsp_q, rsp_d;
    logic              cs_q, cs_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              ad_q, ad_d;
    logic              oe_q, oe_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] bus_in;
    logic              last;
    logic              accept;

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign last      = (cnt_q == LAST);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_q;
    assign rsp_rdata = rdata_q;
    assign cs_n      = cs_q;
    assign rd_n      = rd_q;
    assign wr_n      = wr_q;
    assign a_d       = ad_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) state_d = ST_ADDR;
            end
            ST_ADDR: if (last) begin state_d = ST_GAP;  cnt_d = '0; end
            ST_GAP:  if (last) begin state_d = ST_DATA; cnt_d = '0; end
            ST_DATA: if (last) begin state_d = ST_END;  cnt_d = '0; end
            ST_END:  if (last) begin state_d = ST_IDLE; cnt_d = '0; end
            default: begin state_d = ST_IDLE; cnt_d = '0; end
        endcase
    end

    always_comb begin
        write_d = accept ? req_write : write_q;
        addr_d  = accept ? req_addr  : addr_q;
        wdata_d = accept ? req_wdata : wdata_q;
        rsp_d   = (state_q == ST_END) && last;
        rdata_d = rdata_q;
        if (state_q == ST_DATA && last && !write_q) rdata_d = bus_in;
    end

    // Pins are decoded from the next state so they change cleanly on the edge.
    always_comb begin
        cs_d  = STROBE_OFF;
        rd_d  = STROBE_OFF;
        wr_d  = STROBE_OFF;
        ad_d  = A_D_ADDR;
        oe_d  = 1'b0;
        out_d = '0;
        unique case (state_d)
            ST_ADDR: begin
                cs_d  = STROBE_ON;
                wr_d  = STROBE_ON;
                oe_d  = 1'b1;
                out_d = addr_d;
            end
            ST_GAP: begin
                cs_d = STROBE_ON;
                ad_d = A_D_DATA;
            end
            ST_DATA: begin
                cs_d = STROBE_ON;
                ad_d = A_D_DATA;
                if (write_d) begin
                    wr_d  = STROBE_ON;
                    oe_d  = 1'b1;
                    out_d = wdata_d;
                end else begin
                    rd_d = STROBE_ON;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rsp_q   <= 1'b0;
            cs_q    <= STROBE_OFF;
            rd_q    <= STROBE_OFF;
            wr_q    <= STROBE_OFF;
            ad_q    <= A_D_ADDR;
            oe_q    <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rsp_q   <= rsp_d;
            cs_q    <= cs_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ad_q    <= ad_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
        end
    end

    tristate_io_reg #(
        .W(DATA_W)
    ) u_io (
        .clock    (clock),
        .reset    (reset),
        .oe_i     (oe_q),
        .out_i    (out_q),
        .pad_io   (ad_bus),
        .in_o     (bus_in),
        .sample_o (bus_sample)
    );

endmodule

// File: tb/tb_rtc_ad_bus_ctrl.sv
// Random and directed traffic on two bus masters (P=4/W=8 and P=1/W=4)
// checked cycle by cycle against a transaction-level timing model.
module tb_rtc_ad_bus_ctrl;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rtc;
    } req_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       req_valid [2];
    logic       req_write [2];
    logic [7:0] req_addr  [2];
    logic [7:0] req_wdata [2];

    logic       rdy0, rsp0, busy0, cs0, rd0, wr0, ad0;
    logic       rdy1, rsp1, busy1, cs1, rd1, wr1, ad1;
    logic [7:0] rdata0, samp0;
    logic [3:0] rdata1, samp1;
    wire  [7:0] bus0;
    wire  [3:0] bus1;

    logic [7:0] rtc_cur  [2];
    logic [7:0] rtc_next [2];

    // Simple RTC chip: answers whenever its read strobe is asserted.
    assign bus0 = !rd0 ? rtc_cur[0]      : 8'bz;
    assign bus1 = !rd1 ? rtc_cur[1][3:0] : 4'bz;

    rtc_ad_bus_ctrl #(.DATA_W(8), .PHASE_CYCLES(4)) dut0 (
        .clock(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(rdy0),
        .req_write(req_write[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp0),
        .rsp_rdata(rdata0), .busy(busy0), .ad_bus(bus0),
        .cs_n(cs0), .rd_n(rd0), .wr_n(wr0), .a_d(ad0),
        .bus_sample(samp0)
    );

    rtc_ad_bus_ctrl #(.DATA_W(4), .PHASE_CYCLES(1)) dut1 (
        .clock(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(rdy1),
        .req_write(req_write[1]), .req_addr(req_addr[1][3:0]),
        .req_wdata(req_wdata[1][3:0]), .rsp_valid(rsp1),
        .rsp_rdata(rdata1), .busy(busy1), .ad_bus(bus1),
        .cs_n(cs1), .rd_n(rd1), .wr_n(wr1), .a_d(ad1),
        .bus_sample(samp1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // Transaction model: k counts cycles since accept, phase = (k-1)/P.
    bit         m_act [2];
    int         m_k   [2];
    bit         m_wr  [2];
    logic [7:0] m_addr [2];
    logic [7:0] m_wdata[2];
    logic [7:0] m_rdata[2];
    bit         m_acc [2];
    bit         m_rsp [2];
    bit         s_known[2];
    logic [7:0] s_val  [2];

    function automatic int pcyc(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [7:0] msk(input int i);
        return (i == 0) ? 8'hFF : 8'h0F;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int p;
            p = pcyc(i);
            s_known[i] = 1'b0;
            s_val[i]   = '0;
            if (m_act[i]) begin
                int ph;
                ph = (m_k[i] - 1) / p;
                if (ph == 0) begin
                    s_known[i] = 1'b1; s_val[i] = m_addr[i];
                end else if (ph == 2) begin
                    s_known[i] = 1'b1;
                    s_val[i] = m_wr[i] ? m_wdata[i] : (rtc_cur[i] & msk(i));
                end
            end
            m_acc[i] = 1'b0;
            m_rsp[i] = 1'b0;
            if (reset) begin
                m_act[i]   = 1'b0;
                m_k[i]     = 0;
                m_rdata[i] = '0;
                s_known[i] = 1'b1;
                s_val[i]   = '0;
            end else if (m_act[i]) begin
                if (m_k[i] == 3 * p && !m_wr[i])
                    m_rdata[i] = rtc_cur[i] & msk(i);
                if (m_k[i] == 4 * p) begin
                    m_act[i] = 1'b0;
                    m_rsp[i] = 1'b1;
                end else begin
                    m_k[i]++;
                end
            end else if (req_valid[i]) begin
                m_act[i]   = 1'b1;
                m_k[i]     = 1;
                m_acc[i]   = 1'b1;
                m_wr[i]    = req_write[i];
                m_addr[i]  = req_addr[i] & msk(i);
                m_wdata[i] = req_wdata[i] & msk(i);
                rtc_cur[i] = rtc_next[i] & msk(i);
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic [3:0] e_pins, o_pins;
                logic       e_oe, o_oe;
                logic [7:0] e_bus, o_bus;
                logic       o_rdy, o_rsp, o_busy;
                logic [7:0] o_rdata, o_samp;
                int ph;
                e_pins = 4'b1110;
                e_oe   = 1'b0;
                e_bus  = '0;
                if (m_act[i]) begin
                    ph = (m_k[i] - 1) / pcyc(i);
                    case (ph)
                        0: begin e_pins = 4'b0100; e_oe = 1'b1; e_bus = m_addr[i]; end
                        1: e_pins = 4'b0111;
                        2: if (m_wr[i]) begin
                               e_pins = 4'b0101; e_oe = 1'b1; e_bus = m_wdata[i];
                           end else begin
                               e_pins = 4'b0011;
                           end
                        default: e_pins = 4'b1110;
                    endcase
                end
                if (i == 0) begin
                    o_pins = {cs0, rd0, wr0, ad0}; o_oe = dut0.oe_q;
                    o_bus = bus0; o_rdy = rdy0; o_rsp = rsp0; o_busy = busy0;
                    o_rdata = rdata0; o_samp = samp0;
                end else begin
                    o_pins = {cs1, rd1, wr1, ad1}; o_oe = dut1.oe_q;
                    o_bus = {4'h0, bus1}; o_rdy = rdy1; o_rsp = rsp1;
                    o_busy = busy1; o_rdata = {4'h0, rdata1};
                    o_samp = {4'h0, samp1};
                end
                check($sformatf("pins%0d", i), 32'(o_pins), 32'(e_pins));
                check($sformatf("oe%0d", i), 32'(o_oe), 32'(e_oe));
                check($sformatf("contend%0d", i),
                      32'(o_oe && !o_pins[2]), 32'(0));
                if (e_oe) check($sformatf("bus%0d", i), 32'(o_bus), 32'(e_bus));
                check($sformatf("ready%0d", i), 32'(o_rdy),
                      32'(!m_act[i] && !reset));
                check($sformatf("busy%0d", i), 32'(o_busy), 32'(m_act[i]));
                check($sformatf("rsp%0d", i), 32'(o_rsp), 32'(m_rsp[i]));
                check($sformatf("rdata%0d", i), 32'(o_rdata), 32'(m_rdata[i]));
                if (s_known[i])
                    check($sformatf("sample%0d", i), 32'(o_samp), 32'(s_val[i]));
            end
        end
    end

    req_t q0[$];
    req_t q1[$];
    bit   rand_en = 1'b0;

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            req_t r;
            bit   have;
            if (req_valid[i] && !m_acc[i]) continue;
            have = 1'b0;
            if (i == 0 && q0.size() > 0) begin r = q0.pop_front(); have = 1'b1; end
            else if (i == 1 && q1.size() > 0) begin r = q1.pop_front(); have = 1'b1; end
            else if (rand_en && $urandom_range(0, 2) == 0) begin
                r.wr    = 1'($urandom_range(0, 1));
                r.addr  = 8'($urandom) & msk(i);
                r.wdata = 8'($urandom) & msk(i);
                r.rtc   = 8'($urandom) & msk(i);
                have = 1'b1;
            end
            req_valid[i] = have;
            if (have) begin
                req_write[i] = r.wr;
                req_addr[i]  = r.addr;
                req_wdata[i] = r.wdata;
                rtc_next[i]  = r.rtc;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_act[0] || m_act[1] ||
                req_valid[0] || req_valid[1]) && n < 400) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(n >= 400), 32'(0));
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0;
            req_addr[i] = '0; req_wdata[i] = '0;
            rtc_next[i] = '0; rtc_cur[i] = '0;
        end
        repeat (3) step();
        reset = 1'b0;

        q0.push_back('{1'b1, 8'h21, 8'h5A, 8'h00});
        q0.push_back('{1'b0, 8'h22, 8'h00, 8'h37});
        q0.push_back('{1'b1, 8'h33, 8'h44, 8'h00});
        q1.push_back('{1'b0, 8'h0A, 8'h00, 8'h0A});
        q1.push_back('{1'b1, 8'h05, 8'h03, 8'h00});
        wait_idle();

        q0.push_back('{1'b1, 8'h40, 8'h99, 8'h00});
        begin
            int n;
            n = 0;
            while (!(m_act[0] && m_k[0] == 10) && n < 100) begin
                step();
                n++;
            end
            check("abort_timeout", 32'(n >= 100), 32'(0));
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_idle();

        rand_en = 1'b1;
        repeat (3000) begin
            step();
            reset = ($urandom_range(0, 199) == 0);
        end
        rand_en = 1'b0;
        reset = 1'b0;
        wait_idle();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
